// File: rtl/enum_word_assembler.sv
// Byte-stream to word assembler.
// Collects a framed byte stream (least-significant byte first) into one
// DATA_W-bit word and presents it on a valid/ready output that stays stable
// until the consumer accepts it. Framing errors drop the partial word,
// raise a one-cycle pulse and bump a saturating error counter.
module enum_word_assembler #(
  parameter  int WORD_BYTES = 4,
  parameter  int ERR_CNT_W  = 8,
  localparam int DATA_W     = 8 * WORD_BYTES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_byte,
  input  logic                 in_valid,
  input  logic                 in_sof,
  output logic                 in_ready,
  output logic [DATA_W-1:0]    out_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = (WORD_BYTES > 2) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(WORD_BYTES - 1);

  typedef enum logic [7:0] {
    ST_INITIAL = 8'd0,
    ST_COLLECT = 8'd1,
    ST_HOLD    = 8'd2
  } state_e;

  state_e                 fsm_state_q, fsm_state_d;
  logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0]      partial_q, partial_d;
  logic [DATA_W-1:0]      out_word_q, out_word_d;
  logic                   out_valid_q, out_valid_d;
  logic                   err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

  logic [DATA_W-1:0]      lane_word;
  logic                   err_hit;

  // Bytes are only taken while collecting; INITIAL and HOLD stall the sender.
  assign in_ready  = (fsm_state_q == ST_COLLECT);
  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

  // Next-state, lane write, framing check and error counter update.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    fsm_state_d = fsm_state_q;
    byte_cnt_d  = byte_cnt_q;
    partial_d   = partial_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    err_count_d = err_count_q;
    err_hit     = 1'b0;

    // Partial word with the incoming byte dropped into the current lane.
    lane_word = partial_q;
    lane_word[8*int'(byte_cnt_q) +: 8] = in_byte;

    case (fsm_state_q)
      ST_INITIAL: fsm_state_d = ST_COLLECT;

      ST_COLLECT: begin
        if (in_valid) begin
          if (in_sof) begin
            // A start byte always opens a fresh word; mid-word it is an error.
            err_hit    = (byte_cnt_q != '0);
            partial_d  = {{(DATA_W-8){1'b0}}, in_byte};
            byte_cnt_d = CNT_W'(1);
          end else if (byte_cnt_q == '0) begin
            // Orphan byte with no start of frame: drop it.
            err_hit = 1'b1;
          end else if (byte_cnt_q == LAST_LANE) begin
            out_word_d  = lane_word;
            out_valid_d = 1'b1;
            byte_cnt_d  = '0;
            partial_d   = '0;
            fsm_state_d = ST_HOLD;
          end else begin
            partial_d  = lane_word;
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_state_d = ST_COLLECT;
        end
      end

      default: fsm_state_d = ST_INITIAL;
    endcase

    err_pulse_d = err_hit;
    if (err_hit && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  // State and output registers; reset clears everything, including a pending word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the partial-word register is reset too, so a word cut short by
      // reset can never leak into the next one.
      fsm_state_q <= ST_INITIAL;
      byte_cnt_q  <= '0;
      partial_q   <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      fsm_state_q <= fsm_state_d;
      byte_cnt_q  <= byte_cnt_d;
      partial_q   <= partial_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_enum_word_assembler.sv
// Directed testbench for enum_word_assembler (default 4-byte words, 8-bit counter).
module tb_enum_word_assembler;

  logic        clk;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_sof;
  logic        in_ready;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        err_pulse;
  logic [7:0]  err_count;

  int n_tests;
  int n_fail;

  enum_word_assembler dut (
    .clk       (clk),
    .reset     (reset),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until the block accepts it (bounded wait).
  task automatic push(input logic [7:0] b, input logic sof);
    int waited;
    in_byte  = b;
    in_sof   = sof;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!in_ready) check("push_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_word"},  out_word,           32'd0);
    check({tag, "_err_pulse"}, {31'd0, err_pulse}, 32'd0);
    check({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b0;
    in_byte   = 8'h00;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b1;

    // ---- reset state and dead cycle after release ----
    repeat (3) step();
    check_reset_outputs("rst");
    reset = 1'b1;
    check("dead_cycle_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("collect_in_ready", {31'd0, in_ready}, 32'd1);

    // ---- basic word, consumer ready ----
    push(8'h11, 1'b1);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    push(8'h44, 1'b0);
    check("w1_valid", {31'd0, out_valid}, 32'd1);
    check("w1_word", out_word, 32'h4433_2211);
    check("w1_in_ready_hold", {31'd0, in_ready}, 32'd0);
    check("w1_err_count", {24'd0, err_count}, 32'd0);
    step();
    check("w1_valid_one_cycle", {31'd0, out_valid}, 32'd0);
    check("w1_word_retained", out_word, 32'h4433_2211);

    // ---- backpressure: hold for 5 cycles while a byte waits ----
    out_ready = 1'b0;
    push(8'hA1, 1'b1);
    push(8'hB2, 1'b0);
    push(8'hC3, 1'b0);
    push(8'hD4, 1'b0);
    in_byte  = 8'h99;
    in_sof   = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_word", out_word, 32'hD4C3_B2A1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("hold_released_valid", {31'd0, out_valid}, 32'd0);
    check("hold_released_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
    step();   // the waiting 0x99 start byte transfers here
    in_valid = 1'b0;
    push(8'h88, 1'b0);
    push(8'h77, 1'b0);
    push(8'h66, 1'b0);
    check("w3_word", out_word, 32'h6677_8899);
    check("w3_valid", {31'd0, out_valid}, 32'd1);
    check("w3_err_count", {24'd0, err_count}, 32'd0);
    out_ready = 1'b1;
    step();
    check("w3_released", {31'd0, out_valid}, 32'd0);

    // ---- sof in the middle of a word ----
    push(8'hAA, 1'b1);
    push(8'hBB, 1'b0);
    check("mid_no_pulse_yet", {31'd0, err_pulse}, 32'd0);
    push(8'h01, 1'b1);
    check("mid_err_pulse", {31'd0, err_pulse}, 32'd1);
    check("mid_err_count", {24'd0, err_count}, 32'd1);
    push(8'h02, 1'b0);
    check("mid_pulse_one_cycle", {31'd0, err_pulse}, 32'd0);
    push(8'h03, 1'b0);
    push(8'h04, 1'b0);
    check("mid_word", out_word, 32'h0403_0201);
    check("mid_valid", {31'd0, out_valid}, 32'd1);
    check("mid_err_count_after", {24'd0, err_count}, 32'd1);
    step();

    // ---- orphan byte after reset ----
    reset = 1'b0;
    #1;
    check_reset_outputs("rst2");
    reset = 1'b1;
    step();
    push(8'h55, 1'b0);
    check("orphan_pulse", {31'd0, err_pulse}, 32'd1);
    check("orphan_count", {24'd0, err_count}, 32'd1);
    push(8'hEF, 1'b1);
    push(8'hBE, 1'b0);
    push(8'hAD, 1'b0);
    push(8'hDE, 1'b0);
    check("orphan_word", out_word, 32'hDEAD_BEEF);
    check("orphan_valid", {31'd0, out_valid}, 32'd1);
    check("orphan_count_after", {24'd0, err_count}, 32'd1);
    step();

    // ---- 300 orphan bytes: counter saturates ----
    for (int i = 0; i < 254; i++) push(i[7:0], 1'b0);
    check("sat_reach_255", {24'd0, err_count}, 32'd255);
    for (int i = 0; i < 46; i++) push(i[7:0], 1'b0);
    check("sat_no_wrap", {24'd0, err_count}, 32'd255);
    check("sat_pulse_still", {31'd0, err_pulse}, 32'd1);

    // ---- reset mid-word ----
    push(8'h12, 1'b1);
    push(8'h34, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_mid_count", {24'd0, err_count}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mid_word", out_word, 32'd0);
    reset = 1'b1;
    step();
    step();
    check("rst_mid_no_emit", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    push(8'hC0, 1'b1);
    push(8'hC1, 1'b0);
    push(8'hC2, 1'b0);
    push(8'hC3, 1'b0);
    check("fresh1_word", out_word, 32'hC3C2_C1C0);
    check("fresh1_count", {24'd0, err_count}, 32'd0);

    // ---- reset during HOLD ----
    step();
    check("pre_rst_hold_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_hold");
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      step();
      check("rst_hold_no_emit", {31'd0, out_valid}, 32'd0);
    end
    push(8'h0D, 1'b1);
    push(8'h0C, 1'b0);
    push(8'h0B, 1'b0);
    push(8'h0A, 1'b0);
    check("fresh2_word", out_word, 32'h0A0B_0C0D);
    check("fresh2_valid", {31'd0, out_valid}, 32'd1);
    check("fresh2_count", {24'd0, err_count}, 32'd0);
    step();
    check("fresh2_released", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
